// File: rtl/ecg_pkg.sv
// rtl/ecg_pkg.sv - shared types and default sizes for the ECG classifier datapath
package ecg_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int DEF_LANES  = 16;
  localparam int DEF_ROWS   = 15;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_CLAMP = 2'd3
  } act_mode_e;

endpackage

// File: rtl/act_lane.sv
// rtl/act_lane.sv - combinational single-element activation function
module act_lane #(
  parameter int DATA_WIDTH = ecg_pkg::DATA_WIDTH,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_MAX  = 127
) (
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  ecg_pkg::act_mode_e           mode_i,
  output logic signed [DATA_WIDTH-1:0] y_o
);
  import ecg_pkg::*;

  localparam logic signed [DATA_WIDTH-1:0] CMAX = DATA_WIDTH'(CLAMP_MAX);

  logic x_pos;
  assign x_pos = !x_i[DATA_WIDTH-1] && (x_i != '0);

  // Select the activation; every result fits in DATA_WIDTH so no saturation is needed
  always_comb begin
    y_o = x_i;
    case (mode_i)
      ACT_PASS:  y_o = x_i;
      ACT_RELU:  y_o = x_pos ? x_i : '0;
      ACT_LEAKY: y_o = x_pos ? x_i : (x_i >>> LEAK_SHIFT);
      ACT_CLAMP: begin
        if (!x_pos)         y_o = '0;
        else if (x_i > CMAX) y_o = CMAX;
        else                 y_o = x_i;
      end
      default:   y_o = x_i;
    endcase
  end

endmodule

// File: rtl/relu_stream.sv
// rtl/relu_stream.sv - streaming per-row activation stage with 2-entry output buffer
module relu_stream #(
  parameter int DATA_WIDTH = ecg_pkg::DATA_WIDTH,
  parameter int LANES      = ecg_pkg::DEF_LANES,
  parameter int ROWS       = ecg_pkg::DEF_ROWS,
  parameter int LEAK_SHIFT = 3,
  parameter int CLAMP_MAX  = 127
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       mode_i,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [LANES-1:0][DATA_WIDTH-1:0] m_data,
  output logic                             m_last,
  output logic                             frame_done
);
  import ecg_pkg::*;

  localparam int RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [RCW-1:0] LAST_ROW = RCW'(ROWS - 1);

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] row_t;

  logic [RCW-1:0] row_cnt_q, row_cnt_d;
  act_mode_e      mode_q, mode_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           s_ready_q, s_ready_d;
  row_t           head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic           head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic           frame_done_q, frame_done_d;

  act_mode_e lane_mode;
  row_t      act_data;
  logic      push, pop, in_last;

  // Row 0 of a frame uses the live mode; later rows use the latched copy
  assign lane_mode = (row_cnt_q == '0) ? act_mode_e'(mode_i) : mode_q;
  assign in_last   = (row_cnt_q == LAST_ROW);
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    act_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEAK_SHIFT (LEAK_SHIFT),
      .CLAMP_MAX  (CLAMP_MAX)
    ) u_act (
      .x_i    (s_data[g]),
      .mode_i (lane_mode),
      .y_o    (act_data[g])
    );
  end

  // Row counter and per-frame mode latch advance on each accepted beat
  always_comb begin
    row_cnt_d = row_cnt_q;
    mode_d    = mode_q;
    if (push) begin
      if (row_cnt_q == '0) mode_d = act_mode_e'(mode_i);
      row_cnt_d = in_last ? '0 : row_cnt_q + RCW'(1);
    end
  end

  // Two-entry buffer: head drives the outputs, tail holds the second beat under backpressure
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_data_d = act_data;
          head_last_d = in_last;
          cnt_d       = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = act_data;
          head_last_d = in_last;
        end else if (push) begin
          tail_data_d = act_data;
          tail_last_d = in_last;
          cnt_d       = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          cnt_d       = 2'd1;
        end
      end
    endcase
    s_ready_d    = (cnt_d != 2'd2);
    frame_done_d = pop && head_last_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_q    <= '0;
      mode_q       <= ACT_PASS;
      cnt_q        <= 2'd0;
      s_ready_q    <= 1'b0;
      head_data_q  <= '0;
      head_last_q  <= 1'b0;
      tail_data_q  <= '0;
      tail_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_cnt_q    <= row_cnt_d;
      mode_q       <= mode_d;
      cnt_q        <= cnt_d;
      s_ready_q    <= s_ready_d;
      head_data_q  <= head_data_d;
      head_last_q  <= head_last_d;
      tail_data_q  <= tail_data_d;
      tail_last_q  <= tail_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_ready    = s_ready_q && !rst;
  assign m_valid    = (cnt_q != 2'd0);
  assign m_data     = head_data_q;
  assign m_last     = head_last_q;
  assign frame_done = frame_done_q;

endmodule
